// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module : cpu_pkg
//  Brief  : Shared types for the 8-bit CPU (opcode enum, instruction layout).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int INSTR_W = 8;

    typedef enum logic [1:0] {
        OP_ONE  = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_SWAP = 2'b11
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [2:0] ra;
        logic [2:0] rb;
    } instr_t;

endpackage

`default_nettype wire

// File: rtl/ifu_fifo2.sv
// ============================================================================
//  Module : ifu_fifo2
//  Brief  : Two-entry FIFO of {instr, instr_pc} with synchronous flush.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifu_fifo2 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr;
    logic              r_rd;
    logic [1:0]        r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_cnt    <= 2'd0;
        end else if (i_flush) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_push_data;
                r_wr        <= ~r_wr;
            end
            if (i_pop) begin
                r_rd <= ~r_rd;
            end
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_cnt;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
//  Module : instr_fetch
//  Brief  : PC owner and single-beat program-memory fetch with valid/ready
//           instruction handoff and redirect flush. IFU_PREFETCH_EN selects a
//           2-deep prefetching variant built on ifu_fifo2.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch
    import cpu_pkg::*;
#(
    parameter int               ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } ifu_state_e;

    localparam logic [ADDR_W-1:0] c_pc_one = 1;

    ifu_state_e        r_state;
    ifu_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic              w_mem_req;

`ifdef IFU_PREFETCH_EN

    logic [ADDR_W-1:0]         r_resp_pc;
    logic [1:0]                r_outst;
    logic [1:0]                r_drop;
    logic [1:0]                w_fifo_cnt;
    logic                      w_fifo_valid;
    logic [INSTR_W+ADDR_W-1:0] w_fifo_data;
    logic                      w_pop;
    logic                      w_resp;
    logic                      w_push;
    logic [2:0]                w_occ;

    // Occupancy counts the slot freed by a same-cycle pop so 1 instr/cycle is sustained.
    always_comb begin
        w_pop       = w_fifo_valid & instr_ready;
        w_occ       = {1'b0, w_fifo_cnt} + {1'b0, r_outst} - {2'b00, w_pop};
        w_resp      = mem_rvalid & (r_outst != 2'd0);
        w_push      = w_resp & (r_drop == 2'd0) & ~redirect_valid;
        w_mem_req   = (r_state != S_IDLE) & ~redirect_valid & (w_occ < 3'd2);
        w_state_nxt = (r_state == S_IDLE) ? S_REQ : r_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_resp_pc <= '0;
            r_outst   <= 2'd0;
            r_drop    <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_outst <= r_outst + {1'b0, w_mem_req} - {1'b0, w_resp};
            if (redirect_valid) begin
                r_pc      <= redirect_pc;
                r_resp_pc <= redirect_pc;
                r_drop    <= r_outst - {1'b0, w_resp};
            end else begin
                if (w_mem_req) begin
                    r_pc <= r_pc + c_pc_one;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + c_pc_one;
                end
                if (w_resp && (r_drop != 2'd0)) begin
                    r_drop <= r_drop - 2'd1;
                end
            end
        end
    end

    ifu_fifo2 #(
        .DATA_W (INSTR_W + ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({mem_rdata, r_resp_pc}),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_valid     (w_fifo_valid),
        .o_data      (w_fifo_data),
        .o_count     (w_fifo_cnt)
    );

    assign instr_valid = w_fifo_valid;
    assign instr       = w_fifo_data[INSTR_W+ADDR_W-1:ADDR_W];
    assign instr_pc    = w_fifo_data[ADDR_W-1:0];

`else

    logic [ADDR_W-1:0] r_req_pc;
    logic              r_drop;
    instr_t            r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;
    logic              w_capture;

    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                w_mem_req   = ~redirect_valid;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_state_nxt = r_drop ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A redirect while a read is still in flight must wait for it to drain.
        if (redirect_valid) begin
            w_state_nxt = (r_state == S_WAIT && !mem_rvalid) ? S_WAIT : S_REQ;
        end
        w_capture = (r_state == S_WAIT) & mem_rvalid & ~r_drop & ~redirect_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_req_pc      <= '0;
            r_drop        <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end else if (w_mem_req) begin
                r_pc <= r_pc + c_pc_one;
            end
            if (w_mem_req) begin
                r_req_pc <= r_pc;
            end
            if (r_state == S_WAIT) begin
                if (mem_rvalid) begin
                    r_drop <= 1'b0;
                end else if (redirect_valid) begin
                    r_drop <= 1'b1;
                end
            end
            if (w_capture) begin
                r_instr       <= instr_t'(mem_rdata);
                r_instr_pc    <= r_req_pc;
                r_instr_valid <= 1'b1;
            end else if (r_instr_valid && (instr_ready || redirect_valid)) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

`endif

    assign mem_req  = w_mem_req;
    assign mem_addr = w_mem_req ? r_pc : '0;
    assign pc       = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
//  Module : tb_instr_fetch
//  Brief  : Randomised scoreboard bench for instr_fetch with a memory model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    localparam int          ADDR_W   = 8;
    localparam logic [7:0]  RESET_PC = 8'h00;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid = 1'b0;
    logic [7:0]        mem_rdata  = 8'h00;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic [7:0]        instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic [ADDR_W-1:0] pc;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .pc             (pc)
    );

    typedef struct { logic [7:0] addr; int due; } pend_t;
    typedef struct { logic [7:0] pc; logic [7:0] data; } exp_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_xfer   = 0;
    int         cyc      = 0;
    int         mem_lat  = 1;
    int         last_due = 0;
    logic [7:0] mem_bytes [256];
    pend_t      pend_q[$];
    exp_t       exp_q[$];
    logic [7:0] exp_req_addr = RESET_PC;
    logic       stale_resp   = 1'b0;
    logic       prev_hold    = 1'b0;
    logic [7:0] prev_instr, prev_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Program memory: in-order responses, latency mem_lat (0 => random 1..3).
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                pend_q.delete();
                last_due   = 0;
                mem_rvalid = 1'b0;
                stale_resp = 1'b1;
            end else if (stale_resp) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 8'hEE;
                stale_resp = 1'b0;
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_bytes[pend_q[0].addr];
                void'(pend_q.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 8'($urandom);
            end
        end
    end

    // Monitor and scoreboard: expected instructions are queued when requested.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_req_addr = RESET_PC;
                prev_hold    = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", instr_valid, 1);
                    check("hold_instr", instr, prev_instr);
                    check("hold_pc", instr_pc, prev_pc);
                end
                if (mem_req) begin
                    int lat;
                    int due;
                    check("mem_addr", mem_addr, exp_req_addr);
                    exp_q.push_back('{exp_req_addr, mem_bytes[exp_req_addr]});
                    lat = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
                    due = cyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pend_q.push_back('{mem_addr, due});
                    exp_req_addr = exp_req_addr + 8'd1;
                end
                if (instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL xfer_unexpected: got pc %0h instr %0h with nothing expected", instr_pc, instr);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("instr_pc", instr_pc, e.pc);
                        check("instr", instr, e.data);
                    end
                    n_xfer++;
                end
                prev_hold  = instr_valid && !instr_ready && !redirect_valid;
                prev_instr = instr;
                prev_pc    = instr_pc;
                if (redirect_valid) begin
                    exp_q.delete();
                    exp_req_addr = redirect_pc;
                end
            end
        end
    end

    task automatic wait_xfers(input int n, input int budget);
        int target = n_xfer + n;
        int c = 0;
        while (n_xfer < target && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (n_xfer < target) begin
            n_checks++;
            $display("FAIL xfer_timeout: got %0d transfers expected %0d", n_xfer, target);
        end
    endtask

    task automatic wait_req(input int budget);
        int c = 0;
        bit seen = 1'b0;
        while (!seen && c < budget) begin
            @(negedge clk);
            seen = mem_req;
            c++;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL req_timeout: got no mem_req within %0d cycles", budget);
        end
    endtask

    task automatic redirect_to(input logic [7:0] target);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        foreach (mem_bytes[i]) mem_bytes[i] = 8'($urandom);
        mem_bytes[0] = 8'h4B;
        mem_bytes[1] = 8'h93;
        mem_bytes[2] = 8'hC0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset while a latency-3 read is outstanding.
        mem_lat     = 3;
        instr_ready = 1'b1;
        wait_req(20);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_pc", pc, RESET_PC);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        mem_lat = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Straight-line 4B/93/C0 at latency 1.
        wait_xfers(3, 40);

        // Backpressure on the first instruction.
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        redirect_to(8'h00);
        begin
            int c = 0;
            while (!instr_valid && c < 20) begin
                @(negedge clk);
                c++;
            end
        end
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", instr_valid, 1);
            check("bp_instr", instr, 8'h4B);
`ifndef IFU_PREFETCH_EN
            check("bp_no_req", mem_req, 0);
`endif
        end
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        wait_xfers(2, 40);

        // Redirect while waiting on a latency-3 read.
        mem_lat = 3;
        wait_req(20);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        wait_xfers(2, 60);

        // PC wrap from 8'hFF.
        mem_lat = 1;
        redirect_to(8'hFF);
        wait_xfers(3, 40);

        // Randomised traffic.
        mem_lat = 0;
        repeat (400) begin
            @(posedge clk);
            #1;
            instr_ready    = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 8'($urandom);
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        mem_lat        = 1;
        wait_xfers(3, 60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
